// File: rtl/gpu_isa_pkg.sv
// ISA constants shared by the warp issue path.
// Instruction field positions and register-index helpers.
package gpu_isa_pkg;

    localparam int INSTR_W  = 64;
    localparam int REG_W    = 8;
    localparam int NUM_REGS = 1 << REG_W;

    localparam int OPCODE_MSB = 63;
    localparam int OPCODE_LSB = 56;
    localparam int PRED_MSB   = 55;
    localparam int PRED_LSB   = 54;
    localparam int RD_MSB     = 53;
    localparam int RD_LSB     = 46;
    localparam int RS0_MSB    = 45;
    localparam int RS0_LSB    = 38;
    localparam int RS1_MSB    = 37;
    localparam int RS1_LSB    = 30;

    typedef logic [REG_W-1:0]    reg_idx_t;
    typedef logic [INSTR_W-1:0]  instr_t;
    typedef logic [NUM_REGS-1:0] reg_mask_t;

    localparam reg_idx_t REG_RZ = '0;

    typedef struct packed {
        reg_idx_t rd;
        reg_idx_t rs0;
        reg_idx_t rs1;
    } reg_fields_t;

    function automatic reg_fields_t decode_regs(input instr_t i);
        reg_fields_t f;
        f.rd  = i[RD_MSB:RD_LSB];
        f.rs0 = i[RS0_MSB:RS0_LSB];
        f.rs1 = i[RS1_MSB:RS1_LSB];
        return f;
    endfunction

    // RZ is never tracked, so it can never block an instruction.
    function automatic logic reg_busy(input reg_mask_t p, input reg_idx_t r);
        return (r != REG_RZ) && p[r];
    endfunction

endpackage

// File: rtl/warp_issue_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req starting at ptr, wrapping, and grants the first hit.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic [PTR_W-1:0] idx;
    logic             found;

    // NUM_REQ is a power of two, so the index wraps by width alone.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr + PTR_W'(i);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/warp_issue_scheduler.sv
// Warp issue scheduler: per-warp scoreboard, round-robin pick,
// and a one-entry registered issue slot feeding the decoder.
module warp_issue_scheduler
    import gpu_isa_pkg::*;
#(
    parameter  int NUM_WARPS = 4,
    localparam int WID_W     = $clog2(NUM_WARPS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_WARPS-1:0]         inst_valid,
    input  logic [INSTR_W*NUM_WARPS-1:0] inst_data,
    output logic [NUM_WARPS-1:0]         inst_ready,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [INSTR_W-1:0]           issue_instr,
    output logic [WID_W-1:0]             issue_warp,
    input  logic                         wb_valid,
    input  logic [WID_W-1:0]             wb_warp,
    input  logic [REG_W-1:0]             wb_rd,
    output logic                         wb_err
);

    reg_mask_t [NUM_WARPS-1:0] pending;

    logic [NUM_WARPS-1:0] hazard;
    logic [NUM_WARPS-1:0] eligible;
    logic [NUM_WARPS-1:0] grant;
    logic [WID_W-1:0]     rr_ptr;
    logic [WID_W-1:0]     win;
    logic                 slot_free;
    logic                 accept;
    instr_t               win_instr;
    reg_fields_t          win_regs;
    logic                 wb_busy;

    always_comb begin
        hazard = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            hazard[w] =
                reg_busy(pending[w], inst_data[INSTR_W*w+RD_LSB  +: REG_W]) |
                reg_busy(pending[w], inst_data[INSTR_W*w+RS0_LSB +: REG_W]) |
                reg_busy(pending[w], inst_data[INSTR_W*w+RS1_LSB +: REG_W]);
        end
    end

    assign slot_free = !issue_valid || issue_ready;
    assign eligible  = inst_valid & ~hazard & {NUM_WARPS{slot_free}};

    rr_arbiter #(
        .NUM_REQ (NUM_WARPS)
    ) u_arb (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    assign inst_ready = rst ? '0 : grant;
    assign accept     = |grant;

    always_comb begin
        win = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (grant[w]) win = WID_W'(w);
        end
    end

    assign win_instr = inst_data[INSTR_W*win +: INSTR_W];
    assign win_regs  = decode_regs(win_instr);
    assign wb_busy   = pending[wb_warp][wb_rd];

    // A set needs the bit clear, so set and clear never hit the same bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid <= 1'b0;
            issue_instr <= '0;
            issue_warp  <= '0;
            wb_err      <= 1'b0;
            rr_ptr      <= '0;
            pending     <= '0;
        end else begin
            if (wb_valid && wb_rd != REG_RZ) begin
                if (wb_busy) pending[wb_warp][wb_rd] <= 1'b0;
                else         wb_err <= 1'b1;
            end
            if (accept) begin
                issue_valid <= 1'b1;
                issue_instr <= win_instr;
                issue_warp  <= win;
                rr_ptr      <= win + WID_W'(1);
                if (win_regs.rd != REG_RZ)
                    pending[win][win_regs.rd] <= 1'b1;
            end else if (issue_ready) begin
                issue_valid <= 1'b0;
            end
        end
    end

endmodule
